// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue queue: opcode encodings,
// flag bit positions inside the response flag nibble, and the command record.
package alu_issue_pkg;

    // Default widths of the ALU command fields
    localparam int WIDTH_DEF = 128;
    localparam int OPW_DEF   = 4;
    localparam int SHW_DEF   = 5;
    localparam int TAG_W_DEF = 4;

    // Opcode encodings understood by the ALU (the queue never decodes them)
    localparam logic [3:0] ADD     = 4'd0;
    localparam logic [3:0] SUB     = 4'd1;
    localparam logic [3:0] MUL     = 4'd2;
    localparam logic [3:0] ROL     = 4'd3;
    localparam logic [3:0] ROR     = 4'd4;
    localparam logic [3:0] SLT     = 4'd5;
    localparam logic [3:0] SGE     = 4'd6;
    localparam logic [3:0] AND     = 4'd7;
    localparam logic [3:0] IDLE_OP = 4'hF;

    // Bit positions within the 4-bit flag field {sign, overflow, zero, carry}
    localparam int FLG_CARRY = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_SIGN  = 3;

    // One ALU command as accepted on the command handshake
    typedef struct packed {
        logic [OPW_DEF-1:0]   opcode;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [SHW_DEF-1:0]   shift;
        logic [TAG_W_DEF-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// dout whenever the FIFO is non-empty; dout reads as zero when empty so the
// consumer-facing fields have a defined value after reset.
module alu_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_en;
    logic          pop_en;

    // Writes into a full FIFO and reads from an empty one are ignored
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = empty ? '0 : mem[rd_ptr_reg];

    // Storage array; contents need no reset because empty masks the output
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); push+pop holds count
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Command front-end for the pipelined ALU. Buffers tagged commands, issues
// one per cycle onto the non-stallable ALU port when a response slot is
// guaranteed, tracks each issue through a fixed-latency delay line, and
// captures the matching result into an in-order response FIFO.
module alu_issue_queue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int OPW     = 4,
    parameter int SHW     = 5,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    // command handshake
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shift,
    input  logic [TAG_W-1:0] cmd_tag,
    // ALU issue port
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [SHW-1:0]   alu_shiftValue,
    // ALU result port
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_sign,
    // response handshake
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
);

    localparam int CW    = $clog2(DEPTH) + 1;      // FIFO count width
    localparam int NSTG  = 1 + ALU_LAT;            // issue register + ALU latency
    localparam int IW    = $clog2(NSTG + 1);       // inflight counter width
    localparam int CMD_W = OPW + 2*WIDTH + SHW + TAG_W;
    localparam int RSP_W = TAG_W + WIDTH + 4;

    // Command FIFO
    logic             cmd_push;
    logic             cmd_full;
    logic             cmd_empty;
    logic [CW-1:0]    cmd_count;
    logic [CMD_W-1:0] cmd_din;
    logic [CMD_W-1:0] cmd_head;

    // Head fields of the command FIFO
    logic [OPW-1:0]   head_opcode;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [SHW-1:0]   head_shift;
    logic [TAG_W-1:0] head_tag;

    // Issue and credit bookkeeping
    logic             issue;
    logic             capture;
    logic [IW-1:0]    inflight_reg;
    logic [CW:0]      used_slots;

    // Delay line tracking issued commands until their result is ready
    logic [NSTG-1:0]  dly_valid_reg;
    logic [TAG_W-1:0] dly_tag_reg [NSTG];

    // Response FIFO
    logic             rsp_pop;
    logic             rsp_full;
    logic             rsp_empty;
    logic [CW-1:0]    rsp_count;
    logic [RSP_W-1:0] rsp_din;
    logic [RSP_W-1:0] rsp_head;
    logic [3:0]       alu_flags;

    // ------------------------------------------------------------------
    // Command side
    // ------------------------------------------------------------------
    assign cmd_ready = rst && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_din   = {cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag};

    alu_sync_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (issue),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    assign head_tag    = cmd_head[0 +: TAG_W];
    assign head_shift  = cmd_head[TAG_W +: SHW];
    assign head_b      = cmd_head[TAG_W + SHW +: WIDTH];
    assign head_a      = cmd_head[TAG_W + SHW + WIDTH +: WIDTH];
    assign head_opcode = cmd_head[TAG_W + SHW + 2*WIDTH +: OPW];

    // A slot is reserved for every in-flight result, so issuing only while
    // queued + in-flight responses stay below DEPTH means capture never
    // meets a full response FIFO. Both terms are registered, so a pop frees
    // its credit one cycle later.
    assign used_slots = (CW+1)'(rsp_count) + (CW+1)'(inflight_reg);
    assign issue      = !cmd_empty && (used_slots < (CW+1)'(DEPTH));

    // ALU drive registers: head of the FIFO on issue, idle pattern otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_opcode     <= OPW'(IDLE_OP);
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end else if (issue) begin
            alu_opcode     <= head_opcode;
            alu_input1     <= head_a;
            alu_input2     <= head_b;
            alu_shiftValue <= head_shift;
        end else begin
            alu_opcode     <= OPW'(IDLE_OP);
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Delay line: stage 0 mirrors the ALU drive register, the last stage
    // lines up with the ALU result of that same command
    // ------------------------------------------------------------------
    // Shift {valid, tag} along with the command's progress through the ALU
    always_ff @(posedge clk) begin
        if (!rst) begin
            dly_valid_reg <= '0;
            for (int i = 0; i < NSTG; i++) begin
                dly_tag_reg[i] <= '0;
            end
        end else begin
            dly_valid_reg  <= {dly_valid_reg[NSTG-2:0], issue};
            dly_tag_reg[0] <= head_tag;
            for (int i = 1; i < NSTG; i++) begin
                dly_tag_reg[i] <= dly_tag_reg[i-1];
            end
        end
    end

    assign capture = dly_valid_reg[NSTG-1];

    // Count commands between issue and capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_reg <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight_reg <= inflight_reg + IW'(1);
                2'b01:   inflight_reg <= inflight_reg - IW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // Pack the ALU flag wires into the response flag nibble
    always_comb begin
        alu_flags            = '0;
        alu_flags[FLG_CARRY] = alu_carry;
        alu_flags[FLG_ZERO]  = alu_zero;
        alu_flags[FLG_OVF]   = alu_ovf;
        alu_flags[FLG_SIGN]  = alu_sign;
    end

    assign rsp_din = {dly_tag_reg[NSTG-1], alu_result, alu_flags};
    assign rsp_pop = rsp_valid && rsp_ready;

    alu_sync_fifo #(
        .W     (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_valid  = !rsp_empty;
    assign rsp_flags  = rsp_head[3:0];
    assign rsp_result = rsp_head[4 +: WIDTH];
    assign rsp_tag    = rsp_head[4 + WIDTH +: TAG_W];

    // A capture into a full response FIFO would silently drop a result
    assert property (@(posedge clk) disable iff (!rst) capture |-> !rsp_full);

    // The command FIFO count can never exceed its capacity
    assert property (@(posedge clk) disable iff (!rst) cmd_count <= CW'(DEPTH));

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: a behavioural 2-cycle ALU, directed command
// vectors with hand-computed results, and a scoreboard monitor that checks
// every response popped from the design.
module tb_alu_issue_queue;
    import alu_issue_pkg::*;

    localparam int WIDTH = 128, OPW = 4, SHW = 5, TAG_W = 4, DEPTH = 8, ALU_LAT = 2;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [OPW-1:0]   cmd_opcode, alu_opcode;
    logic [WIDTH-1:0] cmd_a, cmd_b, alu_input1, alu_input2, alu_result, rsp_result;
    logic [SHW-1:0]   cmd_shift, alu_shiftValue;
    logic [TAG_W-1:0] cmd_tag, rsp_tag;
    logic             alu_carry, alu_zero, alu_ovf, alu_sign;
    logic [3:0]       rsp_flags;

    alu_issue_queue #(
        .WIDTH(WIDTH), .OPW(OPW), .SHW(SHW), .TAG_W(TAG_W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    // ---------------- behavioural ALU: inputs registered, then result ----
    logic [OPW-1:0]   m_op;
    logic [WIDTH-1:0] m_a, m_b;
    logic [SHW-1:0]   m_sh;

    function automatic logic [WIDTH+3:0] alu_model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh);
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] r;
        logic             c, v;
        t = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            ADD: begin
                t = {1'b0, a} + {1'b0, b}; r = t[WIDTH-1:0]; c = t[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            SUB: begin
                t = {1'b0, a} - {1'b0, b}; r = t[WIDTH-1:0]; c = t[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            AND:     r = a & b;
            ROL:     r = (a << sh) | (a >> (WIDTH - int'(sh)));
            default: r = '0;
        endcase
        return {r, c, (r == '0), v, r[WIDTH-1]};
    endfunction

    always @(posedge clk) begin
        m_op <= alu_opcode; m_a <= alu_input1; m_b <= alu_input2; m_sh <= alu_shiftValue;
        {alu_result, alu_carry, alu_zero, alu_ovf, alu_sign} <= alu_model(m_op, m_a, m_b, m_sh);
    end

    // ---------------- bookkeeping ----------------
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
        logic [3:0]       flags;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    int   cyc = 0, last_acc_cyc = 0, n_popped = 0;
    int   issue_cnt = 0, alu_run = 0, alu_run_max = 0, rsp_run = 0, rsp_run_max = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH+7:0] act, input logic [WIDTH+7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every response accepted by the consumer
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got tag %0h result %0h, expected no response", rsp_tag, rsp_result);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_tag", rsp_tag, mon_e.tag);
                check("rsp_result", rsp_result, mon_e.res);
                check("rsp_flags", rsp_flags, mon_e.flags);
                n_popped++;
                $display("rsp tag=%0h result=%0h flags=%b", rsp_tag, rsp_result, rsp_flags);
            end
        end
    end

    // Issue and back-to-back run counters
    always @(negedge clk) begin
        if (alu_opcode != IDLE_OP) begin
            issue_cnt++; alu_run++;
        end else begin
            alu_run = 0;
        end
        if (alu_run > alu_run_max) alu_run_max = alu_run;
        if (rsp_valid && rsp_ready) rsp_run++; else rsp_run = 0;
        if (rsp_run > rsp_run_max) rsp_run_max = rsp_run;
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk); #2;
    endtask

    function automatic alu_cmd_t mk(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [SHW-1:0] sh, input logic [TAG_W-1:0] tag);
        alu_cmd_t c;
        c.opcode = op; c.a = a; c.b = b; c.shift = sh; c.tag = tag;
        return c;
    endfunction

    // Offer one command (valid stays high on return so calls chain back to back)
    task automatic send_cmd(input alu_cmd_t c, input logic [WIDTH-1:0] er, input logic [3:0] ef,
                            input int max_wait, output bit ok);
        int w;
        w = 0; ok = 1'b1;
        cmd_opcode = c.opcode; cmd_a = c.a; cmd_b = c.b; cmd_shift = c.shift; cmd_tag = c.tag;
        cmd_valid = 1'b1;
        while (!cmd_ready) begin
            if (w >= max_wait) begin
                ok = 1'b0; cmd_valid = 1'b0;
                return;
            end
            sync(); w++;
        end
        sync();
        sb_q.push_back('{c.tag, er, ef});
        last_acc_cyc = cyc;
    endtask

    task automatic send_req(input alu_cmd_t c, input logic [WIDTH-1:0] er, input logic [3:0] ef);
        bit ok;
        send_cmd(c, er, ef, 50, ok);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: tag %0h not accepted, expected acceptance", c.tag);
        end
    endtask

    task automatic wait_latency(input string name);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (n == 20) begin
            checks++; errors++;
            $display("FAIL %s: no rsp_valid within 20 cycles, expected latency 4", name);
        end else begin
            check(name, cyc - last_acc_cyc, 4);
        end
        sync();
    endtask

    task automatic drain(input int budget);
        int n;
        rsp_ready = 1'b1;
        for (n = 0; n < budget && sb_q.size() != 0; n++) sync();
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (3) sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        bit ok;
        int acc, pop0, first_acc, vcnt;
        rst = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        cmd_shift = '0; cmd_tag = '0; rsp_ready = 1'b0;
        repeat (2) sync();

        // Reset state
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_alu_opcode", alu_opcode, 4'hF);
        check("reset_alu_input1", alu_input1, 0);
        check("reset_alu_input2", alu_input2, 0);
        check("reset_alu_shift", alu_shiftValue, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_fields", {rsp_tag, rsp_result, rsp_flags}, 0);
        sync();
        rst = 1'b1;
        sync();
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Single ADD with latency check
        rsp_ready = 1'b1;
        send_req(mk(ADD, 5, 7, 0, 3), 12, 4'b0000);
        cmd_valid = 1'b0;
        wait_latency("add_latency");
        drain(50);

        // Flag and operation variety
        send_req(mk(AND, 'hFF, 'h0F, 0, 4), 'h0F, 4'b0000);
        send_req(mk(ADD, ONES, 1, 0, 5), 0, 4'b0011);
        send_req(mk(ROL, {1'b1, 126'b0, 1'b1}, 0, 4, 6), 'h18, 4'b0000);
        cmd_valid = 1'b0;
        drain(50);

        // 8 back-to-back commands, consumer always ready
        alu_run_max = 0; rsp_run_max = 0;
        for (int i = 0; i < 8; i++) send_req(mk(ADD, WIDTH'(i), 100, 0, TAG_W'(i)), WIDTH'(i + 100), 4'b0000);
        cmd_valid = 1'b0;
        drain(50);
        check("b2b_alu_no_gap", alu_run_max, 8);
        check("b2b_rsp_consecutive", rsp_run_max, 8);

        // Consumer stalled: 8 issued, 16 accepted, then back-pressure
        rsp_ready = 1'b0; issue_cnt = 0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            send_cmd(mk(ADD, WIDTH'(i), 200, 0, TAG_W'(i)), WIDTH'(i + 200), 4'b0000, 10, ok);
            if (!ok) break;
            acc++;
        end
        cmd_valid = 1'b0;
        check("stall_accepted", acc, 16);
        check("stall_issued", issue_cnt, 8);
        check("stall_cmd_ready", cmd_ready, 0);
        pop0 = n_popped;
        drain(200);
        check("stall_delivered", n_popped - pop0, 16);

        // Response FIFO at DEPTH-1 with pop and capture on the same edge
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_req(mk(ADD, WIDTH'(i + 1000), 1, 0, TAG_W'(i + 8)), WIDTH'(i + 1001), 4'b0000);
            if (i == 0) first_acc = last_acc_cyc;
        end
        cmd_valid = 1'b0;
        while (cyc < first_acc + 10) sync();
        check("rsp_count_at_depth_m1", dut.u_rsp_fifo.count, 7);
        rsp_ready = 1'b1;
        sync();
        check("rsp_count_pop_and_capture", dut.u_rsp_fifo.count, 7);
        check("rsp_head_advanced", rsp_tag, 9);
        drain(50);

        // Reset with 3 commands in flight and 2 queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_req(mk(ADD, WIDTH'(i), 1, 0, TAG_W'(i)), WIDTH'(i + 1), 4'b0000);
        cmd_valid = 1'b0;
        repeat (8) sync();
        for (int i = 5; i < 10; i++) send_req(mk(ADD, WIDTH'(i), 1, 0, TAG_W'(i)), WIDTH'(i + 1), 4'b0000);
        cmd_valid = 1'b0;
        rst = 1'b0;
        sync();
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        check("mid_reset_alu_opcode", alu_opcode, 4'hF);
        rsp_ready = 1'b1; vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) vcnt++;
        end
        check("no_rsp_after_reset", vcnt, 0);
        sync();
        send_req(mk(SUB, 0, 1, 0, 9), ONES, 4'b1001);
        cmd_valid = 1'b0;
        wait_latency("post_reset_latency");
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
